// File: rtl/fib_result_collector.sv
// Collects results from an upstream fibonacci calculator into a small FIFO.
// A capture happens on each rising edge of in_valid. Each entry holds the term
// index and the result. Captures that arrive while the FIFO is full are dropped
// and counted. The head entry is presented from registered storage.
module fib_result_collector #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_result,
  input  logic [2:0]                 in_term,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_result,
  output logic [2:0]                 out_term,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = DATA_WIDTH + 3;

  // Storage is deliberately not reset; occupancy alone defines validity.
  logic [EntryW-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            valid_q;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic            capture;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            drop;
  logic [EntryW-1:0] head;

  // Event decode: rising edge of in_valid, pop handshake, and push/drop arbitration.
  always_comb begin
    capture = in_valid & ~valid_q;
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    // A clear cycle swallows any capture or pop.
    pop     = ~clear & ~empty & out_ready;
    // When full, a simultaneous pop frees the slot the capture needs.
    push    = ~clear & capture & (~full | pop);
    drop    = ~clear & capture & full & ~pop;
  end

  // Next-state for pointers, occupancy and drop bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= in_valid;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_term, in_result};
    end
  end

  // Head presentation; zeros when empty so stale storage never leaks out.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_valid  = ~empty;
    out_result = empty ? '0 : head[DATA_WIDTH-1:0];
    out_term   = empty ? '0 : head[EntryW-1:DATA_WIDTH];
    count      = count_q;
    overflow   = overflow_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule

// File: tb/tb_fib_result_collector.sv
// Directed self-checking bench for fib_result_collector (DATA_WIDTH=8, DEPTH=4).
module tb_fib_result_collector;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_result;
  logic [2:0] in_term;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_term;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  fib_result_collector #(
    .DATA_WIDTH(8),
    .DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_result (in_result),
    .in_term   (in_term),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_term  (out_term),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture event: raise in_valid for a cycle, then drop it.
  task automatic push(input logic [7:0] r, input logic [2:0] t);
    in_result = r;
    in_term   = t;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_q [$];
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_term   = '0;
    out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    #10;
    rst_n = 1'b1;

    // Single capture, head held while not ready
    in_result = 8'h15;
    in_term   = 3'd7;
    in_valid  = 1'b1;
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_result", 32'(out_result), 32'h15);
    check("single_term", 32'(out_term), 32'd7);
    check("single_count", 32'(count), 32'd1);

    // Level hold: 10 more cycles high, still one entry
    in_result = 8'h99;
    repeat (10) tick();
    check("hold_count", 32'(count), 32'd1);
    check("hold_result", 32'(out_result), 32'h15);
    check("hold_term", 32'(out_term), 32'd7);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_count", 32'(count), 32'd0);
    check("pop_valid", 32'(out_valid), 32'd0);
    check("empty_result", 32'(out_result), 32'd0);
    check("empty_term", 32'(out_term), 32'd0);

    // Capture and pop together while empty: pop ignored
    out_ready = 1'b1;
    in_result = 8'h21;
    in_term   = 3'd1;
    in_valid  = 1'b1;
    tick();
    check("emptypop_count", 32'(count), 32'd1);
    check("emptypop_result", 32'(out_result), 32'h21);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Ordering and wrap (pointers start at 2 here)
    push(8'd2, 3'd3);
    push(8'd3, 3'd4);
    push(8'd5, 3'd5);
    push(8'd8, 3'd6);
    check("wrap_full", 32'(count), 32'd4);
    exp_q = '{8'd2, 8'd3, 8'd5, 8'd8};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("wrap_order_a", 32'(out_result), 32'(exp_q[i]));
      tick();
    end
    out_ready = 1'b0;
    check("wrap_drained", 32'(count), 32'd0);
    push(8'd13, 3'd7);
    push(8'd21, 3'd0);
    exp_q = '{8'd13, 8'd21};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("wrap_order_b", 32'(out_result), 32'(exp_q[i]));
      tick();
    end
    out_ready = 1'b0;
    check("wrap_end_count", 32'(count), 32'd0);

    // Overflow with saturation
    push(8'h31, 3'd1);
    push(8'h32, 3'd2);
    push(8'h33, 3'd3);
    push(8'h34, 3'd4);
    push(8'h41, 3'd0);
    push(8'h42, 3'd0);
    push(8'h43, 3'd0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop3", 32'(drop_cnt), 32'd3);
    check("ovf_head", 32'(out_result), 32'h31);
    check("ovf_head_term", 32'(out_term), 32'd1);
    repeat (257) push(8'h60, 3'd0);
    check("ovf_sat", 32'(drop_cnt), 32'd255);
    check("ovf_sat_head", 32'(out_result), 32'h31);

    // Clear flushes everything
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);

    // Rising edge during clear is discarded, and valid_q still tracks in_valid
    in_valid = 1'b1;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("clr_capture", 32'(count), 32'd0);
    in_valid = 1'b0;
    tick();

    // Full with simultaneous pop accepts the capture
    push(8'h31, 3'd1);
    push(8'h32, 3'd2);
    push(8'h33, 3'd3);
    push(8'h34, 3'd4);
    in_result = 8'h50;
    in_term   = 3'd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fullpop_count", 32'(count), 32'd4);
    check("fullpop_drop", 32'(drop_cnt), 32'd0);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    exp_q = '{8'h32, 8'h33, 8'h34, 8'h50};
    for (int i = 0; i < 4; i++) begin
      check("fullpop_order", 32'(out_result), 32'(exp_q[i]));
      if (i == 3) check("fullpop_tail_term", 32'(out_term), 32'd5);
      tick();
    end
    out_ready = 1'b0;
    check("fullpop_empty", 32'(count), 32'd0);

    // Asynchronous reset between edges
    push(8'h71, 3'd1);
    push(8'h72, 3'd2);
    push(8'h73, 3'd3);
    check("arst_pre", 32'(count), 32'd3);
    #1;
    in_result = 8'h77;
    in_term   = 3'd3;
    in_valid  = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_result", 32'(out_result), 32'd0);
    rst_n = 1'b1;
    tick();
    check("arst_cap_count", 32'(count), 32'd1);
    check("arst_cap_result", 32'(out_result), 32'h77);
    check("arst_cap_term", 32'(out_term), 32'd3);
    tick();
    check("arst_cap_once", 32'(count), 32'd1);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_result_collector.md
FIB_RESULT_COLLECTOR -- requirements
Module: fib_result_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of result data (matches fibonacci package).
REQ-002 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous flush of FIFO, overflow flag and drop counter.
REQ-006 in_valid  input  1  upstream fibonacci result-valid level.
REQ-007 in_result  input  DATA_WIDTH  upstream fibonacci result.
REQ-008 in_term  input  3  term index applied to the upstream calculator.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  downstream accepts head entry.
REQ-011 out_result  output  DATA_WIDTH  head entry result.
REQ-012 out_term  output  3  head entry term.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 overflow  output  1  sticky: at least one capture dropped since last reset/clear.
REQ-015 drop_cnt  output  8  number of dropped captures, saturating at 255.

Function
REQ-016 Capture event = in_valid high while registered previous in_valid (valid_q) low; valid_q SHALL reset to 0, so in_valid high in the first cycle after reset counts as an event.
REQ-017 In-valid level held high over multiple cycles SHALL produce exactly one capture.
REQ-018 On a capture event, {in_term, in_result} as sampled in that cycle SHALL be written at the write pointer.
REQ-019 Written entry SHALL be visible at the outputs the cycle after the capture when the FIFO was empty (1-cycle latency); out_* SHALL be driven from registered storage, not combinationally from in_*.
REQ-020 Pop occurs when out_valid and out_ready are both high at posedge; out_valid SHALL equal (count != 0).
REQ-021 out_result/out_term SHALL remain stable while out_valid high and out_ready low.
REQ-022 When count == 0, out_result and out_term SHALL read 0.
REQ-023 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 Simultaneous capture and pop with FIFO full SHALL accept the capture (count unchanged, no drop).
REQ-025 Simultaneous capture and pop with FIFO empty: pop ignored (out_valid low), capture stored, count becomes 1.
REQ-026 Capture with FIFO full and no pop SHALL be dropped: FIFO unchanged, overflow set, drop_cnt incremented unless already 255.
REQ-027 count SHALL increment on push-only, decrement on pop-only, hold on both or neither.
REQ-028 clear high SHALL, next cycle, give count 0, pointers 0, overflow 0, drop_cnt 0; a capture or pop in the clear cycle SHALL be discarded; valid_q SHALL still update from in_valid.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force count 0, pointers 0, valid_q 0, overflow 0, drop_cnt 0, out_valid 0, out_result 0, out_term 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; storage array contents need not be reset.
REQ-031 After rst_n release, the first posedge SHALL behave as normal operation.

Verification
REQ-032 Single capture: empty FIFO, in_valid rises with in_result=0x15, in_term=7, out_ready=0 -> next cycle out_valid=1, out_result=0x15, out_term=7, count=1; values hold while out_ready=0.
REQ-033 Level hold: in_valid held high 10 cycles -> exactly one entry, count=1.
REQ-034 Ordering/wrap: DEPTH=4, push results 2,3,5,8 then pop 4, push 13,21, pop 2 -> outputs in order 2,3,5,8,13,21; pointers wrap without loss.
REQ-035 Overflow: fill 4 entries, out_ready=0, 3 more capture events -> count=4, overflow=1, drop_cnt=3, head still first entry; then clear -> count=0, overflow=0, drop_cnt=0.
REQ-036 Full with simultaneous pop: FIFO full, out_ready=1 and capture in same cycle -> no drop, count stays 4, new entry at tail.
REQ-037 Async reset: with 3 entries stored, assert rst_n low between clock edges -> out_valid, count, overflow go 0 before next posedge; in_valid already high at release -> one capture on first posedge.
